// File: rtl/aqed_fifo_monitor.sv
// A-QED functional-consistency monitor for a FIFO under test.
// Feeds BMC-driven words into the FIFO and tags one word as the original and a later
// word with the same value as the duplicate. It tracks words in flight and outstanding
// reads, and when the duplicate comes back out it checks that it matches the original.
module aqed_fifo_monitor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              orig_sel,
  input  logic              dup_sel,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] dut_wdata,
  output logic              dut_wen,
  output logic              dut_ren,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic              dut_valid,
  output logic [SEQ_W-1:0]  occupancy,
  output logic              full,
  output logic              empty,
  output logic              qed_done,
  output logic              qed_check,
  output logic              err_proto
);

  localparam logic [SEQ_W-1:0] DepthW = SEQ_W'(DEPTH);
  localparam logic [SEQ_W-1:0] OneW   = SEQ_W'(1);

  typedef enum logic [1:0] {StIdle, StHaveOrig, StHaveBoth, StDone} state_e;

  state_e state_q, state_d;

  logic [SEQ_W-1:0]  in_seq_q, out_seq_q, occ_q, pend_q;
  logic [SEQ_W-1:0]  orig_idx_q, dup_idx_q;
  logic [DATA_W-1:0] orig_in_q, orig_out_q;
  logic              orig_seen_q, done_q, check_q, err_q;

  logic acc, rd_ev, occ_full, occ_empty;
  logic orig_cap, dup_cap, orig_hit, fin;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (orig_cap) state_d = StHaveOrig;
      StHaveOrig: if (dup_cap)  state_d = StHaveBoth;
      StHaveBoth: if (fin)      state_d = StDone;
      StDone:     state_d = StDone;
      default:    state_d = StIdle;
    endcase
  end

  // Handshakes, strobes and capture enables; reset masks the strobes so nothing leaks out
  always_comb begin
    occ_full  = (occ_q == DepthW);
    occ_empty = (occ_q == '0);
    full      = !reset && occ_full;
    empty     = reset || occ_empty;
    in_ready  = reset || (!occ_full && (state_q != StDone));
    acc       = !reset && clk_en && in_valid && !occ_full && (state_q != StDone);
    dut_wen   = acc;
    dut_wdata = in_data;
    dut_ren   = !reset && clk_en && out_rdy && (occ_q > pend_q);
    rd_ev     = clk_en && dut_valid;
    orig_cap  = (state_q == StIdle) && acc && orig_sel;
    dup_cap   = (state_q == StHaveOrig) && acc && dup_sel && (in_data == orig_in_q);
    orig_hit  = ((state_q == StHaveOrig) || (state_q == StHaveBoth)) && rd_ev &&
                (out_seq_q == orig_idx_q);
    fin       = (state_q == StHaveBoth) && rd_ev && (out_seq_q == dup_idx_q);
    occupancy = occ_q;
    qed_done  = done_q;
    qed_check = check_q;
    err_proto = err_q;
  end

  // Counters, tracked indices/data and sticky flags; illegal moves saturate and flag
  always_ff @(posedge clk) begin
    if (reset) begin
      in_seq_q    <= '0;
      out_seq_q   <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      orig_idx_q  <= '0;
      dup_idx_q   <= '0;
      orig_in_q   <= '0;
      orig_out_q  <= '0;
      orig_seen_q <= 1'b0;
      done_q      <= 1'b0;
      check_q     <= 1'b0;
      err_q       <= 1'b0;
    end else if (clk_en) begin
      if (acc)   in_seq_q  <= in_seq_q + OneW;
      if (rd_ev) out_seq_q <= out_seq_q + OneW;

      if (acc && !rd_ev) begin
        if (occ_full) err_q <= 1'b1;
        else          occ_q <= occ_q + OneW;
      end else if (rd_ev && !acc) begin
        if (occ_empty) err_q <= 1'b1;
        else           occ_q <= occ_q - OneW;
      end

      // A return with nothing outstanding is flagged and not subtracted
      if (rd_ev && (pend_q == '0)) begin
        err_q <= 1'b1;
        if (dut_ren) pend_q <= pend_q + OneW;
      end else if (dut_ren && !rd_ev) begin
        pend_q <= pend_q + OneW;
      end else if (rd_ev && !dut_ren) begin
        pend_q <= pend_q - OneW;
      end

      if (orig_cap) begin
        orig_idx_q <= in_seq_q;
        orig_in_q  <= in_data;
      end
      if (dup_cap) dup_idx_q <= in_seq_q;
      if (orig_hit) begin
        orig_out_q  <= dut_rdata;
        orig_seen_q <= 1'b1;
      end
      if (fin) begin
        done_q  <= 1'b1;
        check_q <= orig_seen_q && (dut_rdata == orig_out_q);
      end
    end
  end

endmodule

// File: tb/tb_aqed_fifo_monitor.sv
// Bench for aqed_fifo_monitor: an ideal FIFO with a 1-cycle read latency stands in for the
// design under test, and a position-based reference model predicts every monitor output.
module tb_aqed_fifo_monitor;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int SEQ_W  = 16;

  logic              clk = 1'b0;
  logic              reset, clk_en, in_valid, in_ready, orig_sel, dup_sel, out_rdy;
  logic [DATA_W-1:0] in_data, dut_wdata, dut_rdata;
  logic              dut_wen, dut_ren, dut_valid;
  logic [SEQ_W-1:0]  occupancy;
  logic              full, empty, qed_done, qed_check, err_proto;

  aqed_fifo_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .orig_sel(orig_sel), .dup_sel(dup_sel), .out_rdy(out_rdy),
    .dut_wdata(dut_wdata), .dut_wen(dut_wen), .dut_ren(dut_ren), .dut_rdata(dut_rdata),
    .dut_valid(dut_valid), .occupancy(occupancy), .full(full), .empty(empty),
    .qed_done(qed_done), .qed_check(qed_check), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words are identified by their absolute write/read position
  int          m_occ, m_pend, m_in_cnt, m_out_cnt, m_orig_pos, m_dup_pos;
  logic [15:0] m_orig_in, m_orig_out;
  bit          m_orig_seen, m_done, m_check, m_err;

  // Stand-in FIFO
  logic [15:0] fifo_q[$];
  bit          ret_valid, spurious;
  logic [15:0] ret_data;
  int          pop_cnt, corrupt_at, wen_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_pend = 0; m_in_cnt = 0; m_out_cnt = 0;
    m_orig_pos = -1; m_dup_pos = -1;
    m_orig_in = '0; m_orig_out = '0;
    m_orig_seen = 0; m_done = 0; m_check = 0; m_err = 0;
    fifo_q.delete();
    ret_valid = 0; ret_data = '0; spurious = 0;
    pop_cnt = 0; corrupt_at = -1; wen_cnt = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b1; out_rdy = 1'b1; in_data = 16'h00aa;
    orig_sel = 1'b1; dup_sel = 1'b0; dut_valid = 1'b0; dut_rdata = '0;
    repeat (cycles) @(posedge clk);
    #1;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_dut_wen", 32'(dut_wen), 32'd0);
    check_eq("rst_dut_ren", 32'(dut_ren), 32'd0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    check_eq("rst_qed_done", 32'(qed_done), 32'd0);
    check_eq("rst_qed_check", 32'(qed_check), 32'd0);
    check_eq("rst_err_proto", 32'(err_proto), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_rdy = 1'b0; orig_sel = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check state
  task automatic step(input bit v, input logic [15:0] d, input bit os, input bit ds,
                      input bit ordy, input bit ce);
    bit          exp_rdy, exp_wen, exp_ren, vld;
    logic [15:0] rdat;
    int          occ_n;
    @(negedge clk);
    in_valid = v; in_data = d; orig_sel = os; dup_sel = ds; out_rdy = ordy; clk_en = ce;
    vld  = ret_valid || spurious;
    rdat = ret_valid ? ret_data : 16'hdead;
    dut_valid = vld; dut_rdata = rdat;
    #1;
    exp_rdy = (m_occ < DEPTH) && !m_done;
    exp_wen = ce && v && exp_rdy;
    exp_ren = ce && ordy && (m_occ > m_pend);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("dut_wen", 32'(dut_wen), 32'(exp_wen));
    check_eq("dut_ren", 32'(dut_ren), 32'(exp_ren));
    check_eq("full", 32'(full), 32'(m_occ == DEPTH));
    check_eq("empty", 32'(empty), 32'(m_occ == 0));
    if (exp_wen) check_eq("dut_wdata", 32'(dut_wdata), 32'(d));

    if (ce) begin
      if (exp_wen) begin
        if (m_orig_pos < 0 && os) begin
          m_orig_pos = m_in_cnt; m_orig_in = d;
        end else if (m_orig_pos >= 0 && m_dup_pos < 0 && ds && d == m_orig_in) begin
          m_dup_pos = m_in_cnt;
        end
        m_in_cnt++;
      end
      if (vld) begin
        if (!m_done && m_orig_pos >= 0 && m_out_cnt == m_orig_pos) begin
          m_orig_out = rdat; m_orig_seen = 1;
        end else if (!m_done && m_dup_pos >= 0 && m_out_cnt == m_dup_pos) begin
          m_done = 1; m_check = m_orig_seen && (rdat == m_orig_out);
        end
        m_out_cnt++;
        if (m_pend == 0) m_err = 1;
        else m_pend--;
      end
      if (exp_ren) m_pend++;
      occ_n = m_occ + (exp_wen ? 1 : 0) - (vld ? 1 : 0);
      if (occ_n < 0) begin m_err = 1; occ_n = 0; end
      if (occ_n > DEPTH) begin m_err = 1; occ_n = DEPTH; end
      m_occ = occ_n;
      ret_valid = 0;
    end

    if (dut_wen) begin
      fifo_q.push_back(in_data);
      wen_cnt++;
    end
    if (dut_ren) begin
      ret_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'h0000;
      if (pop_cnt == corrupt_at) ret_data ^= 16'h0003;
      pop_cnt++;
      ret_valid = 1;
    end
    spurious = 0;

    @(posedge clk);
    #1;
    check_eq("occupancy", 32'(occupancy), 32'(m_occ));
    check_eq("qed_done", 32'(qed_done), 32'(m_done));
    check_eq("qed_check", 32'(qed_check), 32'(m_check));
    check_eq("err_proto", 32'(err_proto), 32'(m_err));
  endtask

  task automatic basic_seq();
    step(1, 16'h0011, 1, 0, 0, 1);
    step(1, 16'h0022, 0, 0, 0, 1);
    step(1, 16'h0011, 0, 1, 0, 1);
    repeat (6) step(0, 16'h0000, 0, 0, 1, 1);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_data = '0; orig_sel = 1'b0;
    dup_sel = 1'b0; out_rdy = 1'b0; dut_valid = 1'b0; dut_rdata = '0;
    model_reset();

    // Basic pass
    do_reset(2);
    basic_seq();
    check_eq("basic_done", 32'(qed_done), 32'd1);
    check_eq("basic_check", 32'(qed_check), 32'd1);
    check_eq("basic_drained", 32'(empty), 32'd1);
    check_eq("done_blocks_input", 32'(in_ready), 32'd0);

    // Corrupted duplicate on the way out
    do_reset(1);
    corrupt_at = 2;
    basic_seq();
    check_eq("corrupt_done", 32'(qed_done), 32'd1);
    check_eq("corrupt_check", 32'(qed_check), 32'd0);

    // Fill to full, then a single read
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1, 16'(i + 1), 0, 0, 0, 1);
    check_eq("fill_wen_pulses", 32'(wen_cnt), 32'd4);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    step(1, 16'h0007, 0, 0, 1, 1);
    step(1, 16'h0007, 0, 0, 0, 1);
    check_eq("after_read_occ", 32'(occupancy), 32'd3);
    check_eq("after_read_ready", 32'(in_ready), 32'd1);

    // Simultaneous write and read return at occupancy 2
    do_reset(1);
    step(1, 16'h0101, 0, 0, 0, 1);
    step(1, 16'h0202, 0, 0, 0, 1);
    step(0, 16'h0000, 0, 0, 1, 1);
    step(1, 16'h0303, 0, 0, 0, 1);
    check_eq("simul_occ", 32'(occupancy), 32'd2);

    // Return with no read pending
    do_reset(1);
    spurious = 1;
    step(0, 16'h0000, 0, 0, 0, 1);
    check_eq("proto_err_set", 32'(err_proto), 32'd1);
    repeat (3) step(1, 16'h0044, 0, 0, 1, 1);
    check_eq("proto_err_sticky", 32'(err_proto), 32'd1);

    // Reset in the middle of a comparison, then a clean run
    do_reset(1);
    step(1, 16'h0011, 1, 0, 0, 1);
    step(1, 16'h0011, 0, 1, 0, 1);
    do_reset(1);
    basic_seq();
    check_eq("rerun_done", 32'(qed_done), 32'd1);
    check_eq("rerun_check", 32'(qed_check), 32'd1);

    // Randomized traffic with gated enables and occasional corruption
    for (int r = 0; r < 6; r++) begin
      do_reset(1);
      if (r % 2 == 1) corrupt_at = int'($urandom_range(0, 12));
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(0, 3) != 0, 16'(16'h0011 * $urandom_range(1, 3)),
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
